// File: rtl/writeback_regfile_block_pkg.sv
// Shared widths, types and the read-port bypass helper for the write-back / register-file block.
package writeback_regfile_block_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        data_t ans;
        addr_t rw;
        logic  en;
    } wb_stage_t;

    // R0 reads zero; otherwise the pending write-back wins over stored data.
    function automatic data_t rd_port(addr_t idx, wb_stage_t stg, data_t rf);
        if (idx == REG_ZERO)
            return '0;
        else if (stg.en && stg.rw == idx)
            return stg.ans;
        else
            return rf;
    endfunction

endpackage

// File: rtl/writeback_regfile_block_if.sv
// Memory-stage input, decode read ports and write-back outputs of the block.
interface writeback_regfile_block_if;
    import writeback_regfile_block_pkg::*;

    data_t mux_ans_dm;
    addr_t RW_dm;
    logic  wb_en_dm;
    logic  stall;
    addr_t rs_addr;
    addr_t rt_addr;
    data_t A_out;
    data_t B_out;
    data_t ans_wb;
    addr_t RW_wb;
    logic  wb_en_wb;
    cnt_t  retire_cnt;

    modport slave (
        input  mux_ans_dm, RW_dm, wb_en_dm, stall, rs_addr, rt_addr,
        output A_out, B_out, ans_wb, RW_wb, wb_en_wb, retire_cnt
    );

    modport master (
        output mux_ans_dm, RW_dm, wb_en_dm, stall, rs_addr, rt_addr,
        input  A_out, B_out, ans_wb, RW_wb, wb_en_wb, retire_cnt
    );

endinterface

// File: rtl/writeback_regfile_block_regfile_2r1w.sv
// 2**ADDR_W x DATA_W register file: one write port (R0 guarded), two combinational read ports.
module writeback_regfile_block_regfile_2r1w
    import writeback_regfile_block_pkg::*;
(
    input  logic  clk4,
    input  logic  rst,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  data_t wdata_i,
    input  addr_t raddr_a_i,
    input  addr_t raddr_b_i,
    output data_t rdata_a_o,
    output data_t rdata_b_o
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk4 or posedge rst) begin
        if (rst)
            regs_q <= '0;
        else if (we_i && waddr_i != REG_ZERO)
            regs_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/writeback_regfile_block.sv
// Write-back stage: registers the memory-stage result, commits it to the register file,
// and serves two decode read ports with same-cycle bypass of the pending write.
module writeback_regfile_block
    import writeback_regfile_block_pkg::*;
(
    input  logic                       clk4,
    input  logic                       rst,
    writeback_regfile_block_if.slave   bus
);

    wb_stage_t stage_q, stage_d;
    cnt_t      cnt_q, cnt_d;
    logic      commit;
    data_t     rf_a, rf_b;

    // A stalled stage holds its pending write; it commits on the first non-stall edge.
    assign commit = stage_q.en & ~bus.stall;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            stage_d.ans = bus.mux_ans_dm;
            stage_d.rw  = bus.RW_dm;
            stage_d.en  = bus.wb_en_dm;
        end
        if (commit)
            cnt_d = cnt_q + cnt_t'(1);
    end

    always_ff @(posedge clk4 or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    writeback_regfile_block_regfile_2r1w u_rf (
        .clk4      (clk4),
        .rst       (rst),
        .we_i      (commit),
        .waddr_i   (stage_q.rw),
        .wdata_i   (stage_q.ans),
        .raddr_a_i (bus.rs_addr),
        .raddr_b_i (bus.rt_addr),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    assign bus.A_out      = rd_port(bus.rs_addr, stage_q, rf_a);
    assign bus.B_out      = rd_port(bus.rt_addr, stage_q, rf_b);
    assign bus.ans_wb     = stage_q.ans;
    assign bus.RW_wb      = stage_q.rw;
    assign bus.wb_en_wb   = stage_q.en;
    assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_regfile_block.sv
// Directed bench for writeback_regfile_block: commit, bypass, R0 guard, stall, reset, counter wrap.
module tb_writeback_regfile_block;

    logic clk4;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    writeback_regfile_block_if bus ();

    writeback_regfile_block dut (
        .clk4 (clk4),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk4);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [4:0] rw, input logic en);
        bus.mux_ans_dm = d;
        bus.RW_dm      = rw;
        bus.wb_en_dm   = en;
    endtask

    task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 5'd0, 1'b0);
        bus.stall = 1'b0;
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        #2;
        chk("rst_ans",  32'(bus.ans_wb),     32'h0);
        chk("rst_rw",   32'(bus.RW_wb),      32'h0);
        chk("rst_en",   32'(bus.wb_en_wb),   32'h0);
        chk("rst_cnt",  32'(bus.retire_cnt), 32'h0);
        chk("rst_A5",   32'(bus.A_out),      32'h0);
        chk("rst_B31",  32'(bus.B_out),      32'h0);
        #6 rst = 1'b0;

        // basic commit: A5 -> R3
        drive(8'hA5, 5'd3, 1'b1);
        tick();
        chk("basic_ans", 32'(bus.ans_wb),   32'hA5);
        chk("basic_rw",  32'(bus.RW_wb),    32'h3);
        chk("basic_en",  32'(bus.wb_en_wb), 32'h1);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        rd(5'd3, 5'd4);
        chk("basic_A3",  32'(bus.A_out),      32'hA5);
        chk("basic_B4",  32'(bus.B_out),      32'h0);
        chk("basic_cnt", 32'(bus.retire_cnt), 32'd1);

        // bypass: regs[7]=11, pending 3C to R7
        drive(8'h11, 5'd7, 1'b1);
        tick();
        drive(8'h3C, 5'd7, 1'b1);
        tick();
        rd(5'd7, 5'd7);
        chk("byp_A7",  32'(bus.A_out),      32'h3C);
        chk("byp_B7",  32'(bus.B_out),      32'h3C);
        chk("byp_cnt", 32'(bus.retire_cnt), 32'd2);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        rd(5'd7, 5'd3);
        chk("post_A7",  32'(bus.A_out),      32'h3C);
        chk("post_B3",  32'(bus.B_out),      32'hA5);
        chk("post_cnt", 32'(bus.retire_cnt), 32'd3);

        // R0 guard
        drive(8'hFF, 5'd0, 1'b1);
        tick();
        rd(5'd0, 5'd0);
        chk("r0_byp_A", 32'(bus.A_out), 32'h0);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        rd(5'd0, 5'd7);
        chk("r0_A",   32'(bus.A_out),      32'h0);
        chk("r0_B7",  32'(bus.B_out),      32'h3C);
        chk("r0_cnt", 32'(bus.retire_cnt), 32'd4);

        // stall with pending 42 -> R9; inputs change but the stage must hold
        drive(8'h42, 5'd9, 1'b1);
        tick();
        bus.stall = 1'b1;
        drive(8'h55, 5'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            rd(5'd9, 5'd10);
            chk("stl_A9",  32'(bus.A_out),      32'h42);
            chk("stl_B10", 32'(bus.B_out),      32'h0);
            chk("stl_en",  32'(bus.wb_en_wb),   32'h1);
            chk("stl_cnt", 32'(bus.retire_cnt), 32'd4);
        end
        bus.stall = 1'b0;
        tick();
        rd(5'd9, 5'd10);
        chk("unstl_A9",  32'(bus.A_out),      32'h42);
        chk("unstl_en",  32'(bus.wb_en_wb),   32'h0);
        chk("unstl_cnt", 32'(bus.retire_cnt), 32'd5);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        chk("unstl_cnt2", 32'(bus.retire_cnt), 32'd5);

        // wb_en_dm=0 still captures data but neither bypasses nor commits
        drive(8'h77, 5'd12, 1'b0);
        tick();
        rd(5'd12, 5'd9);
        chk("noen_ans", 32'(bus.ans_wb), 32'h77);
        chk("noen_rw",  32'(bus.RW_wb),  32'd12);
        chk("noen_A",   32'(bus.A_out),  32'h0);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        rd(5'd12, 5'd9);
        chk("noen_A2",  32'(bus.A_out),      32'h0);
        chk("noen_B9",  32'(bus.B_out),      32'h42);
        chk("noen_cnt", 32'(bus.retire_cnt), 32'd5);

        // mid-run reset discards the pending 99 -> R4
        drive(8'h99, 5'd4, 1'b1);
        tick();
        rst = 1'b1;
        rd(5'd3, 5'd31);
        chk("mrst_ans", 32'(bus.ans_wb),     32'h0);
        chk("mrst_en",  32'(bus.wb_en_wb),   32'h0);
        chk("mrst_cnt", 32'(bus.retire_cnt), 32'h0);
        chk("mrst_A3",  32'(bus.A_out),      32'h0);
        rd(5'd5, 5'd7);
        chk("mrst_A5",  32'(bus.A_out), 32'h0);
        chk("mrst_B7",  32'(bus.B_out), 32'h0);
        drive(8'h00, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        rd(5'd4, 5'd9);
        chk("mrst_A4",   32'(bus.A_out),      32'h0);
        chk("mrst_B9",   32'(bus.B_out),      32'h0);
        chk("mrst_cnt2", 32'(bus.retire_cnt), 32'h0);

        // counter wrap: commit every cycle until FFFF, then one more
        drive(8'h01, 5'd1, 1'b1);
        for (int i = 0; i < 70000 && bus.retire_cnt != 16'hFFFF; i++)
            tick();
        chk("wrap_ffff", 32'(bus.retire_cnt), 32'hFFFF);
        tick();
        chk("wrap_zero", 32'(bus.retire_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
